// File: rtl/slc3_fetch_pkg.sv
// Shared types for the SLC-3 fetch engine.
//   fetch_state_t : fetch FSM state encoding
//   FETCH_CNT_W   : width of the completed-fetch counter
package slc3_fetch_pkg;

    typedef enum logic [2:0] {
        HALTED,
        S_MAR,
        S_MEM,
        S_IR,
        S_PAUSE
    } fetch_state_t;

    localparam int FETCH_CNT_W = 16;

endpackage

// File: rtl/slc3_fetch_unit_edge_detect.sv
// 1-bit rising-edge detector.
//   clk, reset : clock and asynchronous active-high reset
//   i_x        : level input
//   o_edge     : high while i_x is high and was low on the previous clock edge
// The delay flop clears to 0, so an input that is already high when reset
// releases reports an edge during the first cycle.
module slc3_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_x,
    output logic o_edge
);

    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_x;
        end
    end

    assign o_edge = i_x & ~r_q;

endmodule

// File: rtl/slc3_fetch_unit.sv
// SLC-3 instruction-fetch engine: PC/MAR/MDR/IR registers and fetch FSM.
//   clk, reset          : clock, asynchronous active-high reset
//   run_i               : rising edge starts fetching from HALTED
//   continue_i          : rising edge resumes from S_PAUSE
//   mem_rdata           : memory read data, taken on the last S_MEM cycle
//   mem_addr, mem_wdata : MAR and MDR
//   mem_mem_ena         : high in every S_MEM cycle
//   mem_wr_ena          : tied low, this block only reads
//   ir_o, led_o, hex_display_debug : instruction register
//   pc_o                : program counter (wraps modulo 2**ADDR_WIDTH)
//   busy_o              : high in S_MAR / S_MEM / S_IR
//   fetch_count_o       : completed fetches, saturating
// MEM_WAIT must lie in 1..15; it sets how many cycles S_MEM lasts.
module slc3_fetch_unit
    import slc3_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    MEM_WAIT   = 1,
    parameter int                    PAUSE_EN   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_i,
    input  logic                   continue_i,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_mem_ena,
    output logic                   mem_wr_ena,
    output logic [DATA_WIDTH-1:0]  ir_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic [DATA_WIDTH-1:0]  led_o,
    output logic [DATA_WIDTH-1:0]  hex_display_debug,
    output logic                   busy_o,
    output logic [FETCH_CNT_W-1:0] fetch_count_o
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] v);
        return (v == '1) ? v : v + FETCH_CNT_W'(1);
    endfunction

    fetch_state_t            r_state;
    fetch_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   r_mar;
    logic [DATA_WIDTH-1:0]   r_mdr;
    logic [DATA_WIDTH-1:0]   r_ir;
    logic [FETCH_CNT_W-1:0]  r_fetch_count;
    logic [3:0]              r_wait;
    logic                    w_run_edge;
    logic                    w_cont_edge;

    slc3_edge_detect u_run_edge (
        .clk    (clk),
        .reset  (reset),
        .i_x    (run_i),
        .o_edge (w_run_edge)
    );

    slc3_edge_detect u_cont_edge (
        .clk    (clk),
        .reset  (reset),
        .i_x    (continue_i),
        .o_edge (w_cont_edge)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HALTED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Edges seen outside HALTED/S_PAUSE are simply not looked at, so they
    // are lost rather than remembered. In S_PAUSE only continue matters,
    // which makes continue win over a simultaneous run.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            HALTED:  if (w_run_edge) w_next_state = S_MAR;
            S_MAR:   w_next_state = S_MEM;
            S_MEM:   if (r_wait == 4'd0) w_next_state = S_IR;
            S_IR:    w_next_state = (PAUSE_EN != 0) ? S_PAUSE : S_MAR;
            S_PAUSE: if (w_cont_edge) w_next_state = S_MAR;
            default: w_next_state = HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_mar         <= '0;
            r_mdr         <= '0;
            r_ir          <= '0;
            r_fetch_count <= '0;
            r_wait        <= 4'd0;
        end else begin
            case (r_state)
                S_MAR: begin
                    // Fetch from the current PC and post-increment it.
                    r_mar  <= r_pc;
                    r_pc   <= r_pc + ADDR_WIDTH'(1);
                    r_wait <= WAIT_INIT;
                end
                S_MEM: begin
                    if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end else begin
                        r_mdr <= mem_rdata;
                    end
                end
                S_IR: begin
                    r_ir          <= r_mdr;
                    r_fetch_count <= sat_inc(r_fetch_count);
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr          = r_mar;
    assign mem_wdata         = r_mdr;
    assign mem_mem_ena       = (r_state == S_MEM);
    assign mem_wr_ena        = 1'b0;
    assign ir_o              = r_ir;
    assign pc_o              = r_pc;
    assign led_o             = r_ir;
    assign hex_display_debug = r_ir;
    assign busy_o            = (r_state == S_MAR) || (r_state == S_MEM) || (r_state == S_IR);
    assign fetch_count_o     = r_fetch_count;

endmodule

// File: tb/tb_slc3_fetch_unit.sv
// Scoreboard bench for slc3_fetch_unit. Four instances with different
// parameter sets share one clock; each has its own reset, run and continue.
// Expected fetches are queued as stimulus is driven and popped by a monitor
// on the cycle the instruction register takes a new word.
module tb_slc3_fetch_unit;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] pc;
        logic [15:0] cnt;
        logic [15:0] len;
        logic [15:0] lat;
        logic        busy;
    } exp_t;

    localparam int MW1 = 1;
    localparam int MW2 = 3;
    localparam int MW4 = 1;
    localparam int MW5 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mw(input logic [15:0] a);
        logic [31:0] t;
        t = {16'b0, a} * 32'd40503;
        return t[15:0] ^ 16'h5A3C;
    endfunction

    // DUT signals
    logic        rst1 = 1'b1, rst2 = 1'b1, rst4 = 1'b1, rst5 = 1'b1;
    logic        run1 = 1'b0, run2 = 1'b0, run4 = 1'b0, run5 = 1'b0;
    logic        cont1 = 1'b0, cont2 = 1'b0, cont4 = 1'b0, cont5 = 1'b0;
    logic [15:0] rd1, rd2, rd4, rd5;
    logic [15:0] a1, a2, a5, wd1, wd2, wd4, wd5, ir1, ir2, ir4, ir5;
    logic [15:0] pc1, pc2, pc5, led1, led2, led4, led5, hex1, hex2, hex4, hex5;
    logic [15:0] cnt1, cnt2, cnt4, cnt5;
    logic [3:0]  a4, pc4;
    logic        en1, en2, en4, en5, wr1, wr2, wr4, wr5, bz1, bz2, bz4, bz5;

    // Memory model: read data is only correct on the last enable cycle.
    int ec1 = 0, ec2 = 0, ec4 = 0, ec5 = 0;
    always @(posedge clk) begin
        ec1 <= en1 ? ec1 + 1 : 0;
        ec2 <= en2 ? ec2 + 1 : 0;
        ec4 <= en4 ? ec4 + 1 : 0;
        ec5 <= en5 ? ec5 + 1 : 0;
    end
    assign rd1 = (en1 && ec1 == MW1 - 1) ? mw(a1) : 16'hDEAD;
    assign rd2 = (en2 && ec2 == MW2 - 1) ? mw(a2) : 16'hDEAD;
    assign rd4 = (en4 && ec4 == MW4 - 1) ? mw({12'b0, a4}) : 16'hDEAD;
    assign rd5 = (en5 && ec5 == MW5 - 1) ? mw(a5) : 16'hDEAD;

    slc3_fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RESET_PC(16'h3000),
                      .MEM_WAIT(MW1), .PAUSE_EN(1)) dut1 (
        .clk(clk), .reset(rst1), .run_i(run1), .continue_i(cont1), .mem_rdata(rd1),
        .mem_addr(a1), .mem_wdata(wd1), .mem_mem_ena(en1), .mem_wr_ena(wr1),
        .ir_o(ir1), .pc_o(pc1), .led_o(led1), .hex_display_debug(hex1),
        .busy_o(bz1), .fetch_count_o(cnt1));

    slc3_fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RESET_PC(16'h0100),
                      .MEM_WAIT(MW2), .PAUSE_EN(1)) dut2 (
        .clk(clk), .reset(rst2), .run_i(run2), .continue_i(cont2), .mem_rdata(rd2),
        .mem_addr(a2), .mem_wdata(wd2), .mem_mem_ena(en2), .mem_wr_ena(wr2),
        .ir_o(ir2), .pc_o(pc2), .led_o(led2), .hex_display_debug(hex2),
        .busy_o(bz2), .fetch_count_o(cnt2));

    slc3_fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RESET_PC(4'hF),
                      .MEM_WAIT(MW4), .PAUSE_EN(1)) dut4 (
        .clk(clk), .reset(rst4), .run_i(run4), .continue_i(cont4), .mem_rdata(rd4),
        .mem_addr(a4), .mem_wdata(wd4), .mem_mem_ena(en4), .mem_wr_ena(wr4),
        .ir_o(ir4), .pc_o(pc4), .led_o(led4), .hex_display_debug(hex4),
        .busy_o(bz4), .fetch_count_o(cnt4));

    slc3_fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RESET_PC(16'h0000),
                      .MEM_WAIT(MW5), .PAUSE_EN(0)) dut5 (
        .clk(clk), .reset(rst5), .run_i(run5), .continue_i(cont5), .mem_rdata(rd5),
        .mem_addr(a5), .mem_wdata(wd5), .mem_mem_ena(en5), .mem_wr_ena(wr5),
        .ir_o(ir5), .pc_o(pc5), .led_o(led5), .hex_display_debug(hex5),
        .busy_o(bz5), .fetch_count_o(cnt5));

    // Scoreboard queues, index 0..3 = dut1, dut2, dut4, dut5
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t sb3[$];
    int   start_cyc[4];

    function automatic int qsize(input int d);
        case (d)
            0: return sb0.size();
            1: return sb1.size();
            2: return sb2.size();
            default: return sb3.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int d);
        case (d)
            0: return sb0.pop_front();
            1: return sb1.pop_front();
            2: return sb2.pop_front();
            default: return sb3.pop_front();
        endcase
    endfunction

    task automatic push_exp(input int d, input logic [15:0] addr, input logic [15:0] pc,
                            input logic [15:0] cnt, input int len, input int lat,
                            input logic busy);
        exp_t e;
        e.addr = addr; e.data = mw(addr); e.pc = pc; e.cnt = cnt;
        e.len = 16'(len); e.lat = 16'(lat); e.busy = busy;
        case (d)
            0: sb0.push_back(e);
            1: sb1.push_back(e);
            2: sb2.push_back(e);
            default: sb3.push_back(e);
        endcase
    endtask

    // Monitor state
    logic        prev_en[4];
    logic        pend[4];
    int          elen[4];
    logic [15:0] aseen[4];

    task automatic mon(input int d, input logic rst, input logic en, input logic wr,
                       input logic bz, input logic [15:0] addr, input logic [15:0] ir,
                       input logic [15:0] pc, input logic [15:0] cnt, input logic [15:0] led,
                       input logic [15:0] hex, input logic [15:0] wd);
        exp_t e;
        if (rst) begin
            prev_en[d] = 1'b0;
            pend[d]    = 1'b0;
            elen[d]    = 0;
            return;
        end
        if (pend[d]) begin
            pend[d] = 1'b0;
            if (qsize(d) > 0) begin
                e = qpop(d);
                chk($sformatf("d%0d_addr", d), aseen[d], e.addr);
                chk($sformatf("d%0d_enalen", d), 16'(elen[d]), e.len);
                chk($sformatf("d%0d_ir", d), ir, e.data);
                chk($sformatf("d%0d_led", d), led, e.data);
                chk($sformatf("d%0d_hex", d), hex, e.data);
                chk($sformatf("d%0d_mdr", d), wd, e.data);
                chk($sformatf("d%0d_pc", d), pc, e.pc);
                chk($sformatf("d%0d_cnt", d), cnt, e.cnt);
                chk($sformatf("d%0d_busy", d), 16'(bz), 16'(e.busy));
                chk($sformatf("d%0d_wr", d), 16'(wr), 16'h0);
                chk($sformatf("d%0d_lat", d), 16'(cyc - start_cyc[d]), e.lat);
            end
        end
        if (en && !prev_en[d]) begin
            elen[d]  = 1;
            aseen[d] = addr;
        end else if (en) begin
            elen[d]++;
            if (addr !== aseen[d]) chk($sformatf("d%0d_addr_stable", d), addr, aseen[d]);
        end
        if (!en && prev_en[d]) pend[d] = 1'b1;
        prev_en[d] = en;
    endtask

    always @(negedge clk) begin
        mon(0, rst1, en1, wr1, bz1, a1, ir1, pc1, cnt1, led1, hex1, wd1);
        mon(1, rst2, en2, wr2, bz2, a2, ir2, pc2, cnt2, led2, hex2, wd2);
        mon(2, rst4, en4, wr4, bz4, {12'b0, a4}, ir4, {12'b0, pc4}, cnt4, led4, hex4, wd4);
        mon(3, rst5, en5, wr5, bz5, a5, ir5, pc5, cnt5, led5, hex5, wd5);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int d, input int budget);
        int n = 0;
        while (qsize(d) != 0 && n < budget) begin
            tick(1);
            n++;
        end
        tick(1);
        chk($sformatf("d%0d_drain_left", d), 16'(qsize(d)), 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            prev_en[i] = 1'b0; pend[i] = 1'b0; elen[i] = 0; aseen[i] = 16'h0; start_cyc[i] = 0;
        end
        run4 = 1'b1;   // already high when reset releases: must count as an edge
        tick(2);

        // Reset state
        chk("rst_pc", pc1, 16'h3000);
        chk("rst_ir", ir1, 16'h0000);
        chk("rst_mar", a1, 16'h0000);
        chk("rst_mdr", wd1, 16'h0000);
        chk("rst_cnt", cnt1, 16'h0000);
        chk("rst_ena", 16'(en1), 16'h0);
        chk("rst_busy", 16'(bz1), 16'h0);
        chk("rst_pc4", {12'b0, pc4}, 16'h000F);

        push_exp(2, 16'h000F, 16'h0000, 16'h0001, 1, MW4 + 3, 1'b0);
        start_cyc[2] = cyc;
        rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;
        tick(1);
        run4 = 1'b0;

        // Single fetch from 0x3000 with one wait state
        push_exp(0, 16'h3000, 16'h3001, 16'h0001, 1, MW1 + 3, 1'b0);
        run1 = 1'b1; start_cyc[0] = cyc;
        tick(1); run1 = 1'b0;
        drain(0, 20);

        // Continue held high: one fetch only
        push_exp(0, 16'h3001, 16'h3002, 16'h0002, 1, MW1 + 3, 1'b0);
        cont1 = 1'b1; start_cyc[0] = cyc;
        tick(10);
        chk("hold_pc", pc1, 16'h3002);
        chk("hold_cnt", cnt1, 16'h0002);
        chk("hold_q", 16'(qsize(0)), 16'h0);
        cont1 = 1'b0;
        tick(1);
        push_exp(0, 16'h3002, 16'h3003, 16'h0003, 1, MW1 + 3, 1'b0);
        cont1 = 1'b1; start_cyc[0] = cyc;
        tick(1); cont1 = 1'b0;
        drain(0, 20);

        // Run pulses while paused are ignored
        for (int i = 0; i < 2; i++) begin
            run1 = 1'b1; tick(1); run1 = 1'b0; tick(3);
        end
        chk("pause_run_pc", pc1, 16'h3003);
        chk("pause_run_cnt", cnt1, 16'h0003);
        chk("pause_run_busy", 16'(bz1), 16'h0);

        // Run and continue together in pause: continue wins, one fetch
        push_exp(0, 16'h3003, 16'h3004, 16'h0004, 1, MW1 + 3, 1'b0);
        run1 = 1'b1; cont1 = 1'b1; start_cyc[0] = cyc;
        tick(1); run1 = 1'b0; cont1 = 1'b0;
        drain(0, 20);

        // Three wait states
        push_exp(1, 16'h0100, 16'h0101, 16'h0001, MW2, MW2 + 3, 1'b0);
        run2 = 1'b1; start_cyc[1] = cyc;
        tick(1); run2 = 1'b0;
        drain(1, 30);
        push_exp(1, 16'h0101, 16'h0102, 16'h0002, MW2, MW2 + 3, 1'b0);
        cont2 = 1'b1; start_cyc[1] = cyc;
        tick(1); cont2 = 1'b0;
        drain(1, 30);

        // 4-bit PC wrap: first fetch from F was started at reset release
        drain(2, 30);
        chk("w4_noX", 16'($isunknown({a4, wd4, en4, wr4, ir4, pc4, led4, hex4, bz4, cnt4})), 16'h0);
        push_exp(2, 16'h0000, 16'h0001, 16'h0002, 1, MW4 + 3, 1'b0);
        cont4 = 1'b1; start_cyc[2] = cyc;
        tick(1); cont4 = 1'b0;
        drain(2, 30);
        chk("w4_noX2", 16'($isunknown({a4, wd4, en4, wr4, ir4, pc4, led4, hex4, bz4, cnt4})), 16'h0);

        // Free-run: back-to-back fetches every 3 cycles
        rst5 = 1'b0;
        tick(1);
        for (int k = 0; k < 6; k++)
            push_exp(3, 16'(k), 16'(k + 1), 16'(k + 1), 1, MW5 + 3 + 3 * k, 1'b1);
        run5 = 1'b1; start_cyc[3] = cyc;
        tick(1); run5 = 1'b0;
        drain(3, 60);
        rst5 = 1'b1;
        tick(2);
        rst5 = 1'b0;
        tick(1);

        // Free-run with the counter preloaded near the top
        for (int k = 0; k < 5; k++)
            push_exp(3, 16'(k), 16'(k + 1), (k == 0) ? 16'hFFFE : 16'hFFFF, 1,
                     MW5 + 3 + 3 * k, 1'b1);
        run5 = 1'b1; start_cyc[3] = cyc;
        tick(1); run5 = 1'b0;
        tick(1);                       // in S_MEM of the first fetch
        force dut5.r_fetch_count = 16'hFFFD;
        tick(1);                       // in S_IR, counter not yet written
        release dut5.r_fetch_count;
        drain(3, 60);
        rst5 = 1'b1;

        // Reset during S_MEM
        cont1 = 1'b1; tick(1); cont1 = 1'b0;
        @(posedge clk); #1;
        chk("mid_ena_before", 16'(en1), 16'h1);
        rst1 = 1'b1;
        #1;
        chk("mid_ena_drop", 16'(en1), 16'h0);
        chk("mid_pc", pc1, 16'h3000);
        chk("mid_ir", ir1, 16'h0000);
        chk("mid_cnt", cnt1, 16'h0000);
        chk("mid_busy", 16'(bz1), 16'h0);
        tick(2);
        rst1 = 1'b0;
        tick(2);
        chk("mid_halted_busy", 16'(bz1), 16'h0);
        push_exp(0, 16'h3000, 16'h3001, 16'h0001, 1, MW1 + 3, 1'b0);
        run1 = 1'b1; start_cyc[0] = cyc;
        tick(1); run1 = 1'b0;
        drain(0, 20);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
